instr_fetch_unit: RTL and testbench

//  Instruction-fetch stage that sits directly upstream of the main decoder.

---
 rtl/instr_fetch_unit.sv | 185 ++++++++++++++++++
 tb/tb_instr_fetch_unit.sv | 316 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch_unit.sv
// Instruction-fetch stage: owns the PC, fetches one word per instruction over a
// req/ack handshake and selects the next PC. Optional trap macro: IFETCH_MISALIGN_TRAP_EN.
module instr_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          CNT_W    = 32
) (
    input  logic             clk,
    input  logic             rst,
    output logic             imem_req,
    output logic [31:0]      imem_addr,
    input  logic             imem_ack,
    input  logic [31:0]      imem_rdata,
    output logic [31:0]      instr,
    output logic             instr_valid,
    input  logic             retire,
    input  logic             jump,
    input  logic             branch,
    input  logic             nequal,
    input  logic             jr,
    input  logic             alu_zero,
    input  logic [31:0]      jr_target,
    output logic [31:0]      pc,
    output logic [31:0]      pc_plus4,
    output logic [CNT_W-1:0] retired_cnt,
    output logic             fetch_err
);

`ifdef IFETCH_MISALIGN_TRAP_EN
    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        FETCH = 2'b01,
        EXEC  = 2'b10,
        HALT  = 2'b11
    } state_t;
`else
    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        FETCH = 2'b01,
        EXEC  = 2'b10
    } state_t;
`endif

    state_t             state_r;
    state_t             state_next_s;
    logic [31:0]        pc_r;
    logic [31:0]        instr_r;
    logic               imem_req_r;
    logic               instr_valid_r;
    logic [CNT_W-1:0]   cnt_r;
    logic [31:0]        pc_plus4_s;
    logic [31:0]        branch_off_s;
    logic [31:0]        target_raw_s;
    logic [31:0]        next_pc_s;
    logic               trap_s;
    logic               advance_s;

    assign pc_plus4_s   = pc_r + 32'd4;
    assign branch_off_s = {{14{instr_r[15]}}, instr_r[15:0], 2'b00};
    assign advance_s    = (state_r == EXEC) && retire;

    // Next-PC selection in decoder priority order: jr, jump, taken branch, sequential.
    always_comb begin
        target_raw_s = pc_plus4_s;
        if (jr) begin
            target_raw_s = jr_target;
        end else if (jump) begin
            target_raw_s = {pc_plus4_s[31:28], instr_r[25:0], 2'b00};
        end else if (branch && (alu_zero ^ nequal)) begin
            target_raw_s = pc_plus4_s + branch_off_s;
        end else begin
            target_raw_s = pc_plus4_s;
        end
    end

`ifdef IFETCH_MISALIGN_TRAP_EN
    assign next_pc_s = target_raw_s;
    assign trap_s    = (target_raw_s[1:0] != 2'b00);
`else
    // Misaligned targets are silently realigned to the word boundary.
    assign next_pc_s = target_raw_s & 32'hFFFF_FFFC;
    assign trap_s    = 1'b0;
`endif

    // Next-state logic of the fetch FSM.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            IDLE: begin
                state_next_s = FETCH;
            end
            FETCH: begin
                if (imem_ack) begin
                    state_next_s = EXEC;
                end else begin
                    state_next_s = FETCH;
                end
            end
            EXEC: begin
                if (retire) begin
`ifdef IFETCH_MISALIGN_TRAP_EN
                    if (trap_s) begin
                        state_next_s = HALT;
                    end else begin
                        state_next_s = FETCH;
                    end
`else
                    state_next_s = FETCH;
`endif
                end else begin
                    state_next_s = EXEC;
                end
            end
`ifdef IFETCH_MISALIGN_TRAP_EN
            HALT: begin
                state_next_s = HALT;
            end
`endif
            default: begin
                state_next_s = IDLE;
            end
        endcase
    end

    // State register and registered handshake outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r       <= IDLE;
            imem_req_r    <= 1'b0;
            instr_valid_r <= 1'b0;
        end else begin
            state_r       <= state_next_s;
            imem_req_r    <= (state_next_s == FETCH);
`ifdef IFETCH_MISALIGN_TRAP_EN
            instr_valid_r <= (state_next_s == EXEC) || (state_next_s == HALT);
`else
            instr_valid_r <= (state_next_s == EXEC);
`endif
        end
    end

    // Instruction capture, PC advance and retire counting.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_r    <= RESET_PC;
            instr_r <= 32'h0000_0000;
            cnt_r   <= '0;
        end else begin
            if ((state_r == FETCH) && imem_ack) begin
                instr_r <= imem_rdata;
            end
            if (advance_s) begin
                cnt_r <= cnt_r + CNT_W'(1);
                if (!trap_s) begin
                    pc_r <= next_pc_s;
                end
            end
        end
    end

`ifdef IFETCH_MISALIGN_TRAP_EN
    logic fetch_err_r;

    // Sticky trap flag; only reset leaves HALT.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fetch_err_r <= 1'b0;
        end else begin
            fetch_err_r <= (state_next_s == HALT);
        end
    end

    assign fetch_err = fetch_err_r;
`else
    assign fetch_err = 1'b0;
`endif

    assign imem_req    = imem_req_r;
    assign imem_addr   = pc_r;
    assign instr       = instr_r;
    assign instr_valid = instr_valid_r;
    assign pc          = pc_r;
    assign pc_plus4    = pc_plus4_s;
    assign retired_cnt = cnt_r;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Self-checking bench for instr_fetch_unit: transaction-level reference model,
// directed scenarios with literal expectations, then randomized stimulus.
module tb_instr_fetch_unit;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic [31:0] instr;
    logic        instr_valid;
    logic        retire;
    logic        jump;
    logic        branch;
    logic        nequal;
    logic        jr;
    logic        alu_zero;
    logic [31:0] jr_target;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic [31:0] retired_cnt;
    logic        fetch_err;

    int n_checks = 0;
    int n_fail   = 0;

    // Model: phase 0 = just out of reset, 1 = waiting for instruction,
    // 2 = holding instruction, 3 = trapped.
    int          m_phase;
    logic [31:0] m_pc;
    logic [31:0] m_instr;
    logic [31:0] m_cnt;

    always #5 clk = ~clk;

    instr_fetch_unit #(.RESET_PC(RESET_PC), .CNT_W(32)) dut (
        .clk(clk), .rst(rst),
        .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ack(imem_ack), .imem_rdata(imem_rdata),
        .instr(instr), .instr_valid(instr_valid),
        .retire(retire), .jump(jump), .branch(branch), .nequal(nequal),
        .jr(jr), .alu_zero(alu_zero), .jr_target(jr_target),
        .pc(pc), .pc_plus4(pc_plus4),
        .retired_cnt(retired_cnt), .fetch_err(fetch_err)
    );

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Target address from the instruction-set rules, before any realignment.
    function automatic logic [31:0] exp_target(input logic [31:0] cur_pc, input logic [31:0] iw,
                                               input logic f_jr, input logic f_jump,
                                               input logic f_br, input logic f_ne,
                                               input logic f_z, input logic [31:0] jt);
        logic [31:0] seq;
        longint      off;
        seq = cur_pc + 32'd4;
        if (f_jr) return jt;
        if (f_jump) return (seq & 32'hF000_0000) | ({6'd0, iw[25:0]} * 32'd4);
        if (f_br && (f_z != f_ne)) begin
            off = longint'($signed(iw[15:0])) * 64'sd4;
            return 32'(longint'(seq) + off);
        end
        return seq;
    endfunction

    task automatic model_reset();
        m_phase = 0;
        m_pc    = RESET_PC;
        m_instr = 32'h0;
        m_cnt   = 32'h0;
    endtask

    task automatic model_edge();
        logic [31:0] t;
        if (rst) begin
            model_reset();
        end else if (m_phase == 0) begin
            m_phase = 1;
        end else if (m_phase == 1) begin
            if (imem_ack) begin
                m_instr = imem_rdata;
                m_phase = 2;
            end
        end else if (m_phase == 2) begin
            if (retire) begin
                t     = exp_target(m_pc, m_instr, jr, jump, branch, nequal, alu_zero, jr_target);
                m_cnt = m_cnt + 32'd1;
`ifdef IFETCH_MISALIGN_TRAP_EN
                if (t % 32'd4 != 32'd0) begin
                    m_phase = 3;
                end else begin
                    m_pc    = t;
                    m_phase = 1;
                end
`else
                m_pc    = t - (t % 32'd4);
                m_phase = 1;
`endif
            end
        end
    endtask

    task automatic compare_all();
        chk("imem_req", 32'(imem_req), (m_phase == 1) ? 32'd1 : 32'd0);
        chk("instr_valid", 32'(instr_valid), (m_phase >= 2) ? 32'd1 : 32'd0);
        chk("imem_addr", imem_addr, m_pc);
        chk("pc", pc, m_pc);
        chk("pc_plus4", pc_plus4, m_pc + 32'd4);
        chk("instr", instr, m_instr);
        chk("retired_cnt", retired_cnt, m_cnt);
        chk("fetch_err", 32'(fetch_err), (m_phase == 3) ? 32'd1 : 32'd0);
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        compare_all();
    endtask

    task automatic clear_inputs();
        imem_ack   = 1'b0;
        imem_rdata = 32'h0;
        retire     = 1'b0;
        jump       = 1'b0;
        branch     = 1'b0;
        nequal     = 1'b0;
        jr         = 1'b0;
        alu_zero   = 1'b0;
        jr_target  = 32'h0;
    endtask

    task automatic do_reset();
        clear_inputs();
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    task automatic fetch(input logic [31:0] word, input int waits);
        int guard;
        clear_inputs();
        guard = 0;
        while (m_phase != 1 && guard < 10) begin
            step();
            guard++;
        end
        if (m_phase != 1) chk("fetch_timeout", 32'(m_phase), 32'd1);
        for (int i = 0; i < waits; i++) step();
        imem_ack   = 1'b1;
        imem_rdata = word;
        step();
        clear_inputs();
    endtask

    task automatic retire_with(input logic f_jr, input logic f_jump, input logic f_br,
                               input logic f_ne, input logic f_z, input logic [31:0] jt);
        jr = f_jr; jump = f_jump; branch = f_br; nequal = f_ne; alu_zero = f_z;
        jr_target = jt;
        retire = 1'b1;
        step();
        clear_inputs();
    endtask

    task automatic goto_pc(input logic [31:0] target);
        fetch(32'h0000_0000, 0);
        retire_with(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, target);
    endtask

    initial begin
        int rst_hold;
        model_reset();
        clear_inputs();
        rst = 1'b1;
        @(negedge clk);
        compare_all();
        step();

        // Pin the reference model with hand-computed targets.
        chk("model_beq_back", exp_target(32'h40, 32'h1000_FFFF, 0, 0, 1, 0, 1, 0), 32'h0000_0040);
        chk("model_j", exp_target(32'h9000_0010, 32'h0800_0010, 0, 1, 0, 0, 0, 0), 32'h9000_0040);
        chk("model_wrap", exp_target(32'hFFFF_FFFC, 32'h0, 0, 0, 0, 0, 0, 0), 32'h0000_0000);

        // T1: zero-wait ack straight out of reset
        rst = 1'b0;
        imem_ack = 1'b1;
        imem_rdata = 32'h2008_0005;
        step();
        chk("t1_req", 32'(imem_req), 32'd1);
        chk("t1_addr", imem_addr, 32'h0);
        step();
        chk("t1_valid", 32'(instr_valid), 32'd1);
        chk("t1_instr", instr, 32'h2008_0005);
        clear_inputs();
        retire_with(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        chk("t1_next_addr", imem_addr, 32'h4);
        chk("t1_cnt", retired_cnt, 32'd1);

        // T2: beq/bne with offset -1 word
        goto_pc(32'h40);
        fetch(32'h1000_FFFF, 1);
        retire_with(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 32'h0);
        chk("t2_beq_taken", pc, 32'h40);
        fetch(32'h1000_FFFF, 0);
        retire_with(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
        chk("t2_beq_not_taken", pc, 32'h44);
        goto_pc(32'h40);
        fetch(32'h1400_FFFF, 2);
        retire_with(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
        chk("t2_bne_taken", pc, 32'h40);

        // T3: j keeps the upper PC nibble
        goto_pc(32'h9000_0010);
        fetch(32'h0800_0010, 0);
        chk("t3_pc_plus4", pc_plus4, 32'h9000_0014);
        retire_with(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
        chk("t3_jump", pc, 32'h9000_0040);

        // T4: jr beats jump; misaligned jr target
        fetch(32'h0800_0010, 0);
        retire_with(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h100);
        chk("t4_jr_wins", pc, 32'h100);
        fetch(32'h0000_0008, 0);
        retire_with(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h102);
`ifdef IFETCH_MISALIGN_TRAP_EN
        chk("t4_trap_err", 32'(fetch_err), 32'd1);
        chk("t4_trap_req", 32'(imem_req), 32'd0);
        chk("t4_trap_pc", pc, 32'h100);
        step();
        chk("t4_halt_hold", 32'(imem_req), 32'd0);
`else
        chk("t4_realign", pc, 32'h100);
        chk("t4_no_err", 32'(fetch_err), 32'd0);
`endif
        do_reset();

        // T5: reset in the middle of a wait-stated fetch
        goto_pc(32'h200);
        while (m_phase != 1) step();
        step();
        rst = 1'b1;
        #1;
        chk("t5_req_drop", 32'(imem_req), 32'd0);
        chk("t5_pc_reset", pc, RESET_PC);
        imem_ack = 1'b1;
        imem_rdata = 32'hDEAD_BEEF;
        step();
        clear_inputs();
        rst = 1'b0;
        step();
        chk("t5_refetch_addr", imem_addr, RESET_PC);
        chk("t5_late_ack_ignored", instr, 32'h0);

        // T6: stray ack in EXEC, stray retire in FETCH, PC wrap
        fetch(32'h0000_0011, 0);
        imem_ack = 1'b1;
        imem_rdata = 32'h1234_5678;
        step();
        chk("t6_ack_in_exec", instr, 32'h0000_0011);
        clear_inputs();
        retire_with(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        jr = 1'b1; jr_target = 32'h500; retire = 1'b1;
        step();
        clear_inputs();
        chk("t6_retire_in_fetch", pc, 32'h4);
        goto_pc(32'hFFFF_FFFC);
        fetch(32'h0000_0000, 0);
        chk("t6_plus4_wrap", pc_plus4, 32'h0);
        retire_with(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        chk("t6_pc_wrap", pc, 32'h0);

        // Randomized traffic against the model
        rst_hold = 0;
        for (int i = 0; i < 3000; i++) begin
            if (rst_hold > 0) begin
                rst_hold--;
                rst = (rst_hold > 0);
            end else if ($urandom_range(0, 249) == 0) begin
                rst_hold = $urandom_range(1, 3);
                rst = 1'b1;
            end else begin
                rst = 1'b0;
            end
            imem_ack   = ($urandom_range(0, 2) == 0);
            imem_rdata = $urandom;
            retire     = ($urandom_range(0, 2) == 0);
            jr         = ($urandom_range(0, 5) == 0);
            jump       = ($urandom_range(0, 4) == 0);
            branch     = ($urandom_range(0, 2) == 0);
            nequal     = $urandom_range(0, 1) == 1;
            alu_zero   = $urandom_range(0, 1) == 1;
            jr_target  = $urandom;
            if ($urandom_range(0, 3) != 0) jr_target = jr_target & 32'hFFFF_FFFC;
            step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
